// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only); backpressure: n/a.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    IMISS    = 2'd1,
    MDU_BUSY = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int MDU_CNT_W = 4;

  // r0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Register-compare network: forwarding selects plus load-use and branch hazard terms.
// Latency: purely combinational; backpressure: none, consumed by the controller FSM.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeRegE,
  input  logic [4:0] writeRegM,
  input  logic [4:0] writeRegW,
  input  logic       regWriteE,
  input  logic       regWriteM,
  input  logic       regWriteW,
  input  logic       memToRegE,
  input  logic       memToRegM,
  input  logic       branchD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic       lwstall,
  output logic       brstall
);

  // M is younger than W, so its result wins when both match.
  always_comb begin
    forwardAE = FWD_RF;
    forwardBE = FWD_RF;
    if (regWriteM && reg_match(rsE, writeRegM))
      forwardAE = FWD_MEM;
    else if (regWriteW && reg_match(rsE, writeRegW))
      forwardAE = FWD_WB;
    if (regWriteM && reg_match(rtE, writeRegM))
      forwardBE = FWD_MEM;
    else if (regWriteW && reg_match(rtE, writeRegW))
      forwardBE = FWD_WB;
  end

  assign forwardAD = regWriteM & reg_match(rsD, writeRegM);
  assign forwardBD = regWriteM & reg_match(rtD, writeRegM);

  assign lwstall = memToRegE & (reg_match(rsD, rtE) | reg_match(rtD, rtE));

  assign brstall = branchD &
                   ((regWriteE & (reg_match(rsD, writeRegE) | reg_match(rtD, writeRegE))) |
                    (memToRegM & (reg_match(rsD, writeRegM) | reg_match(rtD, writeRegM))));

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush/forward sequencer: FSM for imem misses and multicycle MDU ops.
// Latency: all outputs combinational from state and inputs; backpressure: holds F/D (and E when MDU busy).
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeRegE,
  input  logic [4:0] writeRegM,
  input  logic [4:0] writeRegW,
  input  logic       regWriteE,
  input  logic       regWriteM,
  input  logic       regWriteW,
  input  logic       memToRegE,
  input  logic       memToRegM,
  input  logic       branchD,
  input  logic       pcSrcD,
  input  logic       imem_ready,
  input  logic       mdu_startE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE
);

  localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(MDU_LAT - 1);

  state_t               state, state_nxt;
  logic [MDU_CNT_W-1:0] count, count_nxt;

  logic [1:0] fwd_ae, fwd_be;
  logic       fwd_ad, fwd_bd, lwstall, brstall, hazard;
  logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;

  fwd_unit u_fwd (
    .rsD       (rsD),
    .rtD       (rtD),
    .rsE       (rsE),
    .rtE       (rtE),
    .writeRegE (writeRegE),
    .writeRegM (writeRegM),
    .writeRegW (writeRegW),
    .regWriteE (regWriteE),
    .regWriteM (regWriteM),
    .regWriteW (regWriteW),
    .memToRegE (memToRegE),
    .memToRegM (memToRegM),
    .branchD   (branchD),
    .forwardAE (fwd_ae),
    .forwardBE (fwd_be),
    .forwardAD (fwd_ad),
    .forwardBD (fwd_bd),
    .lwstall   (lwstall),
    .brstall   (brstall)
  );

  assign hazard = lwstall | brstall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_m   = 1'b0;
    case (state)
      RUN, IMISS: begin
        if (mdu_startE) begin
          state_nxt = MDU_BUSY;
          count_nxt = CNT_LOAD;
        end else begin
          state_nxt = imem_ready ? RUN : IMISS;
        end
        // A miss only takes over once registered; the returning cycle falls back to normal rules.
        if (state == IMISS && !imem_ready) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end else begin
          stall_f = hazard | ~imem_ready;
          stall_d = hazard;
          flush_e = hazard;
          flush_d = pcSrcD & ~hazard;
        end
      end
      MDU_BUSY: begin
        if (count != '0)
          count_nxt = count - 1'b1;
        else
          state_nxt = imem_ready ? RUN : IMISS;
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign stallF    = rst & stall_f;
  assign stallD    = rst & stall_d;
  assign stallE    = rst & stall_e;
  assign flushD    = rst & flush_d;
  assign flushE    = rst & flush_e;
  assign flushM    = rst & flush_m;
  assign forwardAD = rst & fwd_ad;
  assign forwardBD = rst & fwd_bd;
  assign forwardAE = rst ? fwd_ae : FWD_RF;
  assign forwardBE = rst ? fwd_be : FWD_RF;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus randomized traffic vs a cycle-budget model.
module tb_hazard_controller;

  localparam int MDU_LAT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic       regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
  logic       branchD, pcSrcD, imem_ready, mdu_startE;
  logic       stallF, stallD, stallE, flushD, flushE, flushM, forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;
  logic [11:0] obs;

  int checks   = 0;
  int failures = 0;

  // Reference model state: busy cycles still to come, and whether imem was not ready at the last edge.
  int busy_left = 0;
  bit miss      = 1'b0;

  always #5 clk = ~clk;

  hazard_controller #(.MDU_LAT(MDU_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .rsD        (rsD),
    .rtD        (rtD),
    .rsE        (rsE),
    .rtE        (rtE),
    .writeRegE  (writeRegE),
    .writeRegM  (writeRegM),
    .writeRegW  (writeRegW),
    .regWriteE  (regWriteE),
    .regWriteM  (regWriteM),
    .regWriteW  (regWriteW),
    .memToRegE  (memToRegE),
    .memToRegM  (memToRegM),
    .branchD    (branchD),
    .pcSrcD     (pcSrcD),
    .imem_ready (imem_ready),
    .mdu_startE (mdu_startE),
    .stallF     (stallF),
    .stallD     (stallD),
    .stallE     (stallE),
    .flushD     (flushD),
    .flushE     (flushE),
    .flushM     (flushM),
    .forwardAD  (forwardAD),
    .forwardBD  (forwardBD),
    .forwardAE  (forwardAE),
    .forwardBE  (forwardBE)
  );

  assign obs = {stallF, stallD, stallE, flushD, flushE, flushM, forwardAD, forwardBD, forwardAE, forwardBE};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_left <= 0;
      miss      <= 1'b0;
    end else begin
      if (busy_left > 0)
        busy_left <= busy_left - 1;
      else if (mdu_startE)
        busy_left <= MDU_LAT;
      miss <= !imem_ready;
    end
  end

  function automatic logic [11:0] model_out();
    logic [1:0] fae, fbe;
    logic fad, fbd, lw, br, h;
    logic sf, sd, se, fd, fe, fm;
    sf = 0; sd = 0; se = 0; fd = 0; fe = 0; fm = 0;
    if (!rst) return 12'd0;
    fae = (regWriteM && rsE != 0 && rsE == writeRegM) ? 2'b10 :
          (regWriteW && rsE != 0 && rsE == writeRegW) ? 2'b01 : 2'b00;
    fbe = (regWriteM && rtE != 0 && rtE == writeRegM) ? 2'b10 :
          (regWriteW && rtE != 0 && rtE == writeRegW) ? 2'b01 : 2'b00;
    fad = regWriteM && rsD != 0 && rsD == writeRegM;
    fbd = regWriteM && rtD != 0 && rtD == writeRegM;
    lw  = memToRegE && rtE != 0 && (rtE == rsD || rtE == rtD);
    br  = branchD && ((regWriteE && writeRegE != 0 && (writeRegE == rsD || writeRegE == rtD)) ||
                      (memToRegM && writeRegM != 0 && (writeRegM == rsD || writeRegM == rtD)));
    h   = lw || br;
    if (busy_left > 0) begin
      sf = 1; sd = 1; se = 1; fm = 1;
    end else if (miss && !imem_ready) begin
      sf = 1; sd = 1; fe = 1;
    end else begin
      sf = h || !imem_ready;
      sd = h;
      fe = h;
      fd = pcSrcD && !h;
    end
    return {sf, sd, se, fd, fe, fm, fad, fbd, fae, fbe};
  endfunction

  task automatic clear_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeRegE = 0; writeRegM = 0; writeRegW = 0;
    regWriteE = 0; regWriteM = 0; regWriteW = 0;
    memToRegE = 0; memToRegM = 0;
    branchD = 0; pcSrcD = 0; mdu_startE = 0; imem_ready = 1;
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    clear_inputs();
    rst = 0;
    memToRegE = 1; rtE = 5; rsD = 5; regWriteM = 1; writeRegM = 8; rsE = 8; pcSrcD = 1; imem_ready = 0;
    #1; exp = 12'd0; checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset_forced_zero obs=%b exp=%b", obs, exp); end
    @(negedge clk); clear_inputs(); rst = 1;
    #1; exp = 12'd0; checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset_release_idle obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_load_use();
    logic [11:0] exp;
    @(negedge clk); clear_inputs();
    memToRegE = 1; regWriteE = 1; rtE = 5; writeRegE = 5; rsD = 5;
    #1; exp = 12'b110010_000000; checks++;
    if (obs !== exp) begin failures++; $display("FAIL load_use_rs obs=%b exp=%b", obs, exp); end
    @(negedge clk); clear_inputs();
    #1; exp = 12'd0; checks++;
    if (obs !== exp) begin failures++; $display("FAIL load_use_release obs=%b exp=%b", obs, exp); end
    @(negedge clk); clear_inputs(); memToRegE = 1; rtE = 7; rtD = 7; rsD = 2;
    #1; exp = 12'b110010_000000; checks++;
    if (obs !== exp) begin failures++; $display("FAIL load_use_rt obs=%b exp=%b", obs, exp); end
    @(negedge clk); clear_inputs(); memToRegE = 1; regWriteE = 1; rtE = 0; rsD = 0; rtD = 0;
    #1; exp = 12'd0; checks++;
    if (obs !== exp) begin failures++; $display("FAIL load_use_r0 obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_forwarding();
    @(negedge clk); clear_inputs();
    regWriteM = 1; writeRegM = 8; regWriteW = 1; writeRegW = 8; rsE = 8;
    #1; checks++;
    if (forwardAE !== 2'b10) begin failures++; $display("FAIL fwd_ae_mem obs=%b exp=10", forwardAE); end
    writeRegM = 0;
    #1; checks++;
    if (forwardAE !== 2'b01) begin failures++; $display("FAIL fwd_ae_wb obs=%b exp=01", forwardAE); end
    rsE = 0;
    #1; checks++;
    if (forwardAE !== 2'b00) begin failures++; $display("FAIL fwd_ae_r0 obs=%b exp=00", forwardAE); end
    writeRegM = 8; rtE = 8; rsD = 8; rtD = 9;
    #1; checks++;
    if (obs !== 12'b000000_10_00_10) begin
      failures++; $display("FAIL fwd_d_and_be obs=%b exp=%b", obs, 12'b000000_10_00_10);
    end
  endtask

  task automatic test_branch_flush();
    logic [11:0] exp;
    @(negedge clk); clear_inputs(); branchD = 1; pcSrcD = 1; rsD = 3; rtD = 4;
    #1; exp = 12'b000100_000000; checks++;
    if (obs !== exp) begin failures++; $display("FAIL branch_flush obs=%b exp=%b", obs, exp); end
    @(negedge clk); clear_inputs();
    #1; exp = 12'd0; checks++;
    if (obs !== exp) begin failures++; $display("FAIL branch_flush_once obs=%b exp=%b", obs, exp); end
    @(negedge clk); clear_inputs(); branchD = 1; pcSrcD = 1; rsD = 3; regWriteE = 1; writeRegE = 3;
    #1; exp = 12'b110010_000000; checks++;
    if (obs !== exp) begin failures++; $display("FAIL branch_raw_e obs=%b exp=%b", obs, exp); end
    @(negedge clk); clear_inputs(); branchD = 1; pcSrcD = 1; rtD = 6; memToRegM = 1; writeRegM = 6;
    #1; exp = 12'b110010_000000; checks++;
    if (obs !== exp) begin failures++; $display("FAIL branch_load_m obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_mdu();
    logic [11:0] exp;
    @(negedge clk); clear_inputs(); mdu_startE = 1;
    #1; exp = 12'd0; checks++;
    if (obs !== exp) begin failures++; $display("FAIL mdu_issue_cycle obs=%b exp=%b", obs, exp); end
    for (int k = 1; k <= MDU_LAT; k++) begin
      @(negedge clk); mdu_startE = (k == 2); pcSrcD = 1;
      #1; exp = 12'b111001_000000; checks++;
      if (obs !== exp) begin failures++; $display("FAIL mdu_busy cycle=%0d obs=%b exp=%b", k, obs, exp); end
    end
    @(negedge clk); mdu_startE = 0;
    #1; exp = 12'b000100_000000; checks++;
    if (obs !== exp) begin failures++; $display("FAIL mdu_release_flushd obs=%b exp=%b", obs, exp); end
    @(negedge clk); clear_inputs();
    #1; exp = 12'd0; checks++;
    if (obs !== exp) begin failures++; $display("FAIL mdu_idle obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_mdu_into_imiss();
    logic [11:0] exp;
    @(negedge clk); clear_inputs(); mdu_startE = 1;
    for (int k = 1; k <= MDU_LAT; k++) begin
      @(negedge clk); mdu_startE = 0; imem_ready = 0;
      #1; exp = 12'b111001_000000; checks++;
      if (obs !== exp) begin failures++; $display("FAIL mdu_over_miss cycle=%0d obs=%b exp=%b", k, obs, exp); end
    end
    @(negedge clk);
    #1; exp = 12'b110010_000000; checks++;
    if (obs !== exp) begin failures++; $display("FAIL mdu_exit_to_miss obs=%b exp=%b", obs, exp); end
    @(negedge clk); imem_ready = 1;
    #1; exp = 12'd0; checks++;
    if (obs !== exp) begin failures++; $display("FAIL mdu_miss_release obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_imiss();
    logic [11:0] exp;
    @(negedge clk); clear_inputs(); imem_ready = 0;
    #1; exp = 12'b100000_000000; checks++;
    if (obs !== exp) begin failures++; $display("FAIL imiss_first obs=%b exp=%b", obs, exp); end
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      #1; exp = 12'b110010_000000; checks++;
      if (obs !== exp) begin failures++; $display("FAIL imiss_hold cycle=%0d obs=%b exp=%b", k, obs, exp); end
    end
    @(negedge clk); imem_ready = 1;
    #1; exp = 12'd0; checks++;
    if (obs !== exp) begin failures++; $display("FAIL imiss_release obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_reset_mid_mdu();
    logic [11:0] exp;
    @(negedge clk); clear_inputs(); mdu_startE = 1;
    @(negedge clk); mdu_startE = 0;
    @(negedge clk); regWriteM = 1; writeRegM = 8; rsE = 8;
    #1; exp = 12'b111001_00_10_00; checks++;
    if (obs !== exp) begin failures++; $display("FAIL rst_pre_busy obs=%b exp=%b", obs, exp); end
    rst = 0;
    #1; exp = 12'd0; checks++;
    if (obs !== exp) begin failures++; $display("FAIL rst_mid_mdu obs=%b exp=%b", obs, exp); end
    @(negedge clk); rst = 1;
    #1; exp = 12'b000000_00_10_00; checks++;
    if (obs !== exp) begin failures++; $display("FAIL rst_release_run obs=%b exp=%b", obs, exp); end
    @(negedge clk);
    #1; checks++;
    if (obs !== exp) begin failures++; $display("FAIL rst_no_residual obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_random();
    logic [11:0] exp;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 99) != 0);
      rsD        = 5'($urandom_range(0, 3));
      rtD        = 5'($urandom_range(0, 3));
      rsE        = 5'($urandom_range(0, 3));
      rtE        = 5'($urandom_range(0, 3));
      writeRegE  = 5'($urandom_range(0, 3));
      writeRegM  = 5'($urandom_range(0, 3));
      writeRegW  = 5'($urandom_range(0, 3));
      regWriteE  = 1'($urandom_range(0, 1));
      regWriteM  = 1'($urandom_range(0, 1));
      regWriteW  = 1'($urandom_range(0, 1));
      memToRegE  = 1'($urandom_range(0, 1));
      memToRegM  = 1'($urandom_range(0, 1));
      branchD    = 1'($urandom_range(0, 1));
      pcSrcD     = 1'($urandom_range(0, 1));
      imem_ready = ($urandom_range(0, 3) != 0);
      mdu_startE = ($urandom_range(0, 9) == 0);
      #1; exp = model_out(); checks++;
      if (obs !== exp) begin failures++; $display("FAIL random cycle=%0d obs=%b exp=%b", n, obs, exp); end
    end
    @(negedge clk); clear_inputs(); rst = 1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch_flush();
    test_mdu();
    test_mdu_into_imiss();
    test_imiss();
    test_reset_mid_mdu();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
